stream_in_mc: RTL and testbench

Next-generation AXI-Stream input stage for Up-Sampling. It accepts the source image as a pixel stream and distributes each pixel to one or more of N_PARALLEL upsp lanes. Lane column ranges overlap by OVERLAP pixels. Each lane has its own FIFO, so lanes consume independently instead of in lock-step. Adds an explicit frame FSM with drain/abort and stream-framing error detection.

---
 rtl/stream_in_mc.sv | 175 +++++++++++++++++
 tb/tb_stream_in_mc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_in_mc.sv
// AXI-Stream input stage: splits each image row across N_PARALLEL overlapping lanes, each lane with its own FIFO.
// Optional: define STREAM_IN_MC_RESYNC_EN to let tuser/tlast resynchronise the column/row counters.
module stream_in_mc #(
    parameter int AXISIN_DATA_WIDTH = 32,
    parameter int UPSP_RDDATA_WIDTH = 32,
    parameter int SRC_IMG_WIDTH     = 1920,
    parameter int SRC_IMG_HEIGHT    = 1080,
    parameter int N_PARALLEL        = 4,
    parameter int OVERLAP           = 3,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                   s_axis_aclk,
    input  logic                                   s_axis_arst,
    input  logic                                   UPSTART,
    input  logic                                   UPEND,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic [AXISIN_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                                   s_axis_tlast,
    input  logic                                   s_axis_tuser,
    input  logic [N_PARALLEL-1:0]                  upsp_ac_rready,
    output logic [N_PARALLEL-1:0]                  ac_upsp_rvalid,
    output logic [N_PARALLEL*UPSP_RDDATA_WIDTH-1:0] ac_upsp_rdata,
    output logic                                   frame_busy,
    output logic                                   frame_done,
    output logic                                   err_tlast,
    output logic                                   err_sof
);

    localparam int BLK = SRC_IMG_WIDTH / N_PARALLEL;
    localparam int CW  = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
    localparam int RW  = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW  = UPSP_RDDATA_WIDTH;
    localparam logic [CW-1:0] COL_LAST = CW'(SRC_IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_IMG_HEIGHT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // The last lane has no right neighbour, so it gets no overlap columns.
    function automatic int lane_end(input int j);
        if (j == N_PARALLEL - 1) return SRC_IMG_WIDTH - 1;
        return (j + 1) * BLK - 1 + OVERLAP;
    endfunction

    state_t                state, state_nxt;
    logic [CW-1:0]         col, pix_col;
    logic [RW-1:0]         row, pix_row;
    logic                  row_wrap, last_pix, accept, flush, start;
    logic [N_PARALLEL-1:0] need, full, empty, push, pop;

`ifdef STREAM_IN_MC_RESYNC_EN
    assign pix_col  = s_axis_tuser ? '0 : col;
    assign pix_row  = s_axis_tuser ? '0 : row;
    assign row_wrap = (pix_col == COL_LAST) | s_axis_tlast;
`else
    assign pix_col  = col;
    assign pix_row  = row;
    assign row_wrap = (pix_col == COL_LAST);
`endif

    always_comb begin
        need = '0;
        for (int j = 0; j < N_PARALLEL; j++) begin
            need[j] = (int'(pix_col) >= j * BLK) && (int'(pix_col) <= lane_end(j));
        end
    end

    assign s_axis_tready = (state == RUN) & (&(~need | ~full));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign flush         = UPEND & (state != IDLE);
    assign start         = UPSTART & (state == IDLE);
    assign last_pix      = (pix_row == ROW_LAST) && (pix_col == COL_LAST);

    always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
        if (s_axis_arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        frame_busy = (state == RUN) || (state == DRAIN);
        case (state)
            IDLE:    if (UPSTART) state_nxt = RUN;
            RUN: begin
                if (UPEND) state_nxt = IDLE;
                else if (accept && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (UPEND) begin
                    state_nxt = IDLE;
                end else if (&empty) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
        if (s_axis_arst) begin
            col <= '0;
            row <= '0;
        end else if (flush || start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (row_wrap) begin
                col <= '0;
                row <= (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
            end else begin
                col <= pix_col + 1'b1;
                row <= pix_row;
            end
        end
    end

    // Framing checks use the raw counters so a resync still reports the misplaced marker.
    always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
        if (s_axis_arst) begin
            err_tlast <= 1'b0;
            err_sof   <= 1'b0;
        end else if (start) begin
            err_tlast <= 1'b0;
            err_sof   <= 1'b0;
        end else if (accept) begin
            if (s_axis_tlast != (col == COL_LAST)) err_tlast <= 1'b1;
            if (s_axis_tuser && (col != '0 || row != '0)) err_sof <= 1'b1;
        end
    end

    for (genvar j = 0; j < N_PARALLEL; j++) begin : g_lane
        logic [DW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [AW:0]   count;

        assign full[j]           = (count == CNT_FULL);
        assign empty[j]          = (count == '0);
        assign push[j]           = accept & need[j];
        assign pop[j]            = ~empty[j] & upsp_ac_rready[j];
        assign ac_upsp_rvalid[j] = ~empty[j];
        assign ac_upsp_rdata[j*DW +: DW] = empty[j] ? '0 : mem[rd_ptr];

        always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
            if (s_axis_arst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[j]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[j])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[j], pop[j]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge s_axis_aclk) begin
            if (push[j]) mem[wr_ptr] <= s_axis_tdata[DW-1:0];
        end
    end

endmodule

// File: tb/tb_stream_in_mc.sv
// Scoreboard bench for stream_in_mc with W=8, H=2, two lanes, overlap 3, FIFO depth 4.
module tb_stream_in_mc;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int N  = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            upstart, upend;
    logic            tvalid, tready, tlast, tuser;
    logic [DW-1:0]   tdata;
    logic [N-1:0]    rready, rvalid;
    logic [N*DW-1:0] rdata;
    logic            busy, done, e_tlast, e_sof;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int mcol, mrow;
    bit mdone;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    stream_in_mc #(
        .AXISIN_DATA_WIDTH(DW), .UPSP_RDDATA_WIDTH(DW), .SRC_IMG_WIDTH(W),
        .SRC_IMG_HEIGHT(H), .N_PARALLEL(N), .OVERLAP(3), .FIFO_DEPTH(4)
    ) dut (
        .s_axis_aclk(clk), .s_axis_arst(rst), .UPSTART(upstart), .UPEND(upend),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .upsp_ac_rready(rready),
        .ac_upsp_rvalid(rvalid), .ac_upsp_rdata(rdata), .frame_busy(busy),
        .frame_done(done), .err_tlast(e_tlast), .err_sof(e_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int lane, input logic [DW-1:0] act);
        if ((lane == 0 && q0.size() == 0) || (lane == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL lane%0d_extra: got %0h expected no word", lane, act);
        end else if (lane == 0) begin
            check("lane0_data", 64'(act), 64'(q0.pop_front()));
        end else begin
            check("lane1_data", 64'(act), 64'(q1.pop_front()));
        end
    endtask

    // Monitor: handshakes are stable at the falling edge and complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (rvalid[0] && rready[0]) pop_check(0, rdata[DW-1:0]);
            if (rvalid[1] && rready[1]) pop_check(1, rdata[2*DW-1:DW]);
        end
    end

    // Reference routing: lane0 owns cols 0..3 plus overlap 4..6, lane1 owns cols 4..7.
    function automatic void model_accept(input logic [DW-1:0] d, input logic last, input logic user);
        int c;
        c = mcol;
`ifdef STREAM_IN_MC_RESYNC_EN
        if (user) begin
            c    = 0;
            mrow = 0;
        end
`endif
        if (c <= 6) q0.push_back(d);
        if (c >= 4 && c <= 7) q1.push_back(d);
        if (mrow == H - 1 && c == W - 1) mdone = 1;
`ifdef STREAM_IN_MC_RESYNC_EN
        if (c == W - 1 || last) begin
`else
        if (c == W - 1) begin
`endif
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol = c + 1;
        end
    endfunction

    task automatic accept_beat(output bit ok);
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (tready) begin
                model_accept(tdata, tlast, tuser);
                acc_cnt++;
                @(posedge clk);
                #1;
                ok = 1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got tready=0 expected a handshake within 300 cycles");
    endtask

    task automatic start_frame();
        upstart = 1'b1;
        @(posedge clk);
        #1;
        upstart = 1'b0;
        mcol = 0;
        mrow = 0;
        mdone = 0;
        acc_cnt = 0;
    endtask

    task automatic send_frame(input int base, input int max_beats, input int bad_last, input int bad_user);
        bit ok;
        int b;
        b = 0;
        while (!mdone && b < max_beats) begin
            tdata  = DW'(base + b);
            tlast  = (mcol == W - 1) || (b == bad_last);
            tuser  = (b == 0) || (b == bad_user);
            tvalid = 1'b1;
            accept_beat(ok);
            if (!ok) break;
            b++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 300 && done_cnt < target; n++) @(posedge clk);
        @(posedge clk);
        #1;
        check("frame_done_count", 64'(done_cnt), 64'(target));
        check("busy_after_done", 64'(busy), 64'd0);
        check("lane0_drained", 64'(q0.size()), 64'd0);
        check("lane1_drained", 64'(q1.size()), 64'd0);
    endtask

    int d_before;

    initial begin
        rst = 1'b1; upstart = 1'b0; upend = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; rready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_errs", 64'({e_tlast, e_sof}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean frame, all lanes ready.
        start_frame();
        check("t1_busy", 64'(busy), 64'd1);
        send_frame(0, 100, -1, -1);
        check("t1_beats", 64'(acc_cnt), 64'd16);
        wait_done(1);
        repeat (5) @(posedge clk);
        #1;
        check("t1_done_once", 64'(done_cnt), 64'd1);
        check("t1_errs", 64'({e_tlast, e_sof}), 64'd0);

        // Lane1 stalled: it fills with beats 4..7 and beat 12 (col 4) blocks.
        rready = 2'b01;
        start_frame();
        fork
            send_frame(100, 100, -1, -1);
            begin
                repeat (40) @(posedge clk);
                #1;
                check("t2_tready_blocked", 64'(tready), 64'd0);
                check("t2_accepted", 64'(acc_cnt), 64'd12);
                check("t2_lane1_rdata", 64'(rdata[2*DW-1:DW]), 64'd104);
                rready = 2'b11;
            end
        join
        wait_done(2);
        check("t2_beats", 64'(acc_cnt), 64'd16);

        // Abort after beat 5 with lane1 holding data.
        rready = 2'b01;
        start_frame();
        send_frame(200, 6, -1, -1);
        check("t3_lane1_pending", 64'(rvalid[1]), 64'd1);
        d_before = done_cnt;
        upend = 1'b1;
        @(posedge clk);
        #1;
        upend = 1'b0;
        q0.delete();
        q1.delete();
        check("t3_rvalid", 64'(rvalid), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_tready", 64'(tready), 64'd0);
        rready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_done", 64'(done_cnt), 64'(d_before));
        start_frame();
        send_frame(300, 100, -1, -1);
        wait_done(3);

        // Early tlast at col 5.
        start_frame();
        send_frame(400, 100, 5, -1);
        wait_done(4);
        check("t4_err_tlast", 64'(e_tlast), 64'd1);
        check("t4_err_sof", 64'(e_sof), 64'd0);

        // tuser on beat 3; UPSTART must also clear the previous tlast error.
        start_frame();
        check("t5_tlast_cleared", 64'(e_tlast), 64'd0);
        send_frame(500, 100, -1, 3);
        wait_done(5);
        check("t5_err_sof", 64'(e_sof), 64'd1);
        check("t5_err_tlast", 64'(e_tlast), 64'd0);

        // Asynchronous reset while draining.
        start_frame();
        send_frame(600, 100, -1, -1);
        check("t6_in_drain", 64'(busy), 64'd1);
        check("t6_lane1_pending", 64'(rvalid[1]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_tready", 64'(tready), 64'd0);
        check("t6_rvalid", 64'(rvalid), 64'd0);
        check("t6_rdata", 64'(rdata), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_errs", 64'({e_tlast, e_sof}), 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", 64'(done_cnt), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
